cnn_layer_accel_weight_config_writer: RTL and testbench



---
 rtl/cnn_layer_accel_wht_pkg.sv | 23 ++
 rtl/cnn_layer_accel_wht_addr_counter.sv | 47 ++++
 rtl/cnn_layer_accel_weight_config_writer.sv | 149 ++++++++++++++
 tb/tb_cnn_layer_accel_weight_config_writer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_layer_accel_wht_pkg.sv
// Shared types and sizes for the CE weight-table write path.
// Holds the loader state enum and the kernel-count/index widths used by the table.
package cnn_layer_accel_wht_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_CFG = 2'd1,
        ST_LOAD     = 2'd2,
        ST_DONE     = 2'd3
    } wht_state_e;

    localparam int KERNEL_3x3_WORDS = 9;
    localparam int WHT_MAX_KERNELS  = 64;
    localparam int WHT_KERN_IDX_W   = $clog2(WHT_MAX_KERNELS);
    localparam int WHT_WORD_CNT_W   = 4;
    localparam int WHT_CHECKSUM_W   = 16;

    // Index width for a table of max_kernels entries; never narrower than 1 bit.
    function automatic int kern_idx_w(input int max_kernels);
        return (max_kernels > 1) ? $clog2(max_kernels) : 1;
    endfunction

endpackage

// File: rtl/cnn_layer_accel_wht_addr_counter.sv
// Nested word/kernel counter mirroring the weight table's internal write counters.
// Ports: clk, rst, clr (sync clear), inc (advance one word), last_kern (final kernel
// index); outputs word_cnt, kern_cnt, word_last, kern_last, final_word.
module cnn_layer_accel_wht_addr_counter
    import cnn_layer_accel_wht_pkg::*;
#(
    parameter int C_KERNEL_WORDS = KERNEL_3x3_WORDS,
    parameter int C_KIDX_W       = WHT_KERN_IDX_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr,
    input  logic                      inc,
    input  logic [C_KIDX_W-1:0]       last_kern,
    output logic [WHT_WORD_CNT_W-1:0] word_cnt,
    output logic [C_KIDX_W-1:0]       kern_cnt,
    output logic                      word_last,
    output logic                      kern_last,
    output logic                      final_word
);

    localparam logic [WHT_WORD_CNT_W-1:0] WORD_MAX =
        WHT_WORD_CNT_W'(C_KERNEL_WORDS - 1);

    assign word_last  = (word_cnt == WORD_MAX);
    assign kern_last  = (kern_cnt == last_kern);
    assign final_word = word_last && kern_last;

    // The kernel index holds at last_kern so it can never run past
    // the configured kernel range.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            word_cnt <= '0;
            kern_cnt <= '0;
        end else if (inc) begin
            if (word_last) begin
                word_cnt <= '0;
                if (!kern_last) begin
                    kern_cnt <= kern_cnt + 1'b1;
                end
            end else begin
                word_cnt <= word_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cnn_layer_accel_weight_config_writer.sv
// Write-side producer for the CE weight table: turns a valid/ready weight stream
// into config_mode / wht_config_wren / wht_config_data in per-kernel order.
// Ports: clk, rst (sync, active-high), job_accept, kernel_config_valid,
// num_kernels, wht_in_valid/wht_in_data/wht_in_ready, config_mode,
// wht_config_wren, wht_config_data, config_done, cfg_error, and
// wht_checksum when CNN_LAYER_ACCEL_WHT_CHECKSUM_EN is defined.
module cnn_layer_accel_weight_config_writer
    import cnn_layer_accel_wht_pkg::*;
#(
    parameter int C_WEIGHT_WIDTH = 16,
    parameter int C_KERNEL_WORDS = KERNEL_3x3_WORDS,
    parameter int C_MAX_KERNELS  = WHT_MAX_KERNELS
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      job_accept,
    input  logic                      kernel_config_valid,
    input  logic [15:0]               num_kernels,
    input  logic                      wht_in_valid,
    input  logic [C_WEIGHT_WIDTH-1:0] wht_in_data,
    output logic                      wht_in_ready,
    output logic                      config_mode,
    output logic                      wht_config_wren,
    output logic [C_WEIGHT_WIDTH-1:0] wht_config_data,
    output logic                      config_done,
`ifdef CNN_LAYER_ACCEL_WHT_CHECKSUM_EN
    output logic [WHT_CHECKSUM_W-1:0] wht_checksum,
`endif
    output logic                      cfg_error
);

    localparam int KW = kern_idx_w(C_MAX_KERNELS);

    localparam logic [15:0] NK_MAX  = 16'(C_MAX_KERNELS - 1);
    localparam logic [KW-1:0] KIDX_MAX = KW'(C_MAX_KERNELS - 1);

    wht_state_e state;

    logic [KW-1:0] last_kern;

    logic                      accept;
    logic                      nk_over;
    logic [WHT_WORD_CNT_W-1:0] word_cnt;
    logic [KW-1:0]             kern_cnt;
    logic                      word_last;
    logic                      kern_last;
    logic                      final_word;

    // A beat that coincides with job_accept belongs to the aborted job
    // and is dropped rather than written.
    assign accept = (state == ST_LOAD) && wht_in_ready
                 && wht_in_valid && !job_accept;

    assign nk_over = (num_kernels > NK_MAX);

    cnn_layer_accel_wht_addr_counter #(
        .C_KERNEL_WORDS (C_KERNEL_WORDS),
        .C_KIDX_W       (KW)
    ) u_addr_counter (
        .clk        (clk),
        .rst        (rst),
        .clr        (job_accept),
        .inc        (accept),
        .last_kern  (last_kern),
        .word_cnt   (word_cnt),
        .kern_cnt   (kern_cnt),
        .word_last  (word_last),
        .kern_last  (kern_last),
        .final_word (final_word)
    );

    // Position indices are kept for assertion hookup only.
    logic unused_cnt;
    assign unused_cnt = ^{word_cnt, kern_cnt, word_last, kern_last};

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_IDLE;
            last_kern       <= '0;
            cfg_error       <= 1'b0;
            config_mode     <= 1'b0;
            wht_in_ready    <= 1'b0;
            wht_config_wren <= 1'b0;
            wht_config_data <= '0;
            config_done     <= 1'b0;
        end else begin
            wht_config_wren <= 1'b0;
            config_done     <= 1'b0;
            if (job_accept) begin
                state        <= ST_WAIT_CFG;
                last_kern    <= '0;
                cfg_error    <= 1'b0;
                config_mode  <= 1'b0;
                wht_in_ready <= 1'b0;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        state <= ST_IDLE;
                    end
                    ST_WAIT_CFG: begin
                        if (kernel_config_valid) begin
                            last_kern    <= nk_over ? KIDX_MAX
                                                    : num_kernels[KW-1:0];
                            cfg_error    <= nk_over;
                            config_mode  <= 1'b1;
                            wht_in_ready <= 1'b1;
                            state        <= ST_LOAD;
                        end
                    end
                    ST_LOAD: begin
                        if (accept) begin
                            wht_config_wren <= 1'b1;
                            wht_config_data <= wht_in_data;
                            if (final_word) begin
                                wht_in_ready <= 1'b0;
                                state        <= ST_DONE;
                            end
                        end
                    end
                    ST_DONE: begin
                        // config_mode stays high through the final write so
                        // the table still advances its kernel group on it.
                        config_mode <= 1'b0;
                        config_done <= 1'b1;
                        state       <= ST_IDLE;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

`ifdef CNN_LAYER_ACCEL_WHT_CHECKSUM_EN
    logic [WHT_CHECKSUM_W-1:0] csum;

    always_ff @(posedge clk) begin
        if (rst || job_accept) begin
            csum <= '0;
        end else if (accept) begin
            csum <= csum + WHT_CHECKSUM_W'(wht_in_data);
        end
    end

    assign wht_checksum = csum;
`endif

endmodule

// File: tb/tb_cnn_layer_accel_weight_config_writer.sv
// Directed bench for cnn_layer_accel_weight_config_writer.
// Scoreboard of accepted beats checks every table write in order.
module tb_cnn_layer_accel_weight_config_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        job_accept = 1'b0;
    logic        kernel_config_valid = 1'b0;
    logic [15:0] num_kernels = '0;
    logic        wht_in_valid = 1'b0;
    logic [15:0] wht_in_data = '0;
    logic        wht_in_ready;
    logic        config_mode;
    logic        wht_config_wren;
    logic [15:0] wht_config_data;
    logic        config_done;
    logic        cfg_error;
`ifdef CNN_LAYER_ACCEL_WHT_CHECKSUM_EN
    logic [15:0] wht_checksum;
`endif

    int vecs = 0;
    int errs = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    cnn_layer_accel_weight_config_writer dut (
        .clk                 (clk),
        .rst                 (rst),
        .job_accept          (job_accept),
        .kernel_config_valid (kernel_config_valid),
        .num_kernels         (num_kernels),
        .wht_in_valid        (wht_in_valid),
        .wht_in_data         (wht_in_data),
        .wht_in_ready        (wht_in_ready),
        .config_mode         (config_mode),
        .wht_config_wren     (wht_config_wren),
        .wht_config_data     (wht_config_data),
        .config_done         (config_done),
`ifdef CNN_LAYER_ACCEL_WHT_CHECKSUM_EN
        .wht_checksum        (wht_checksum),
`endif
        .cfg_error           (cfg_error)
    );

    // Handshake model: a beat is taken when valid&&ready outside reset and abort.
    always @(posedge clk) begin
        if (!rst && !job_accept && wht_in_valid && wht_in_ready)
            exp_q.push_back(wht_in_data);
    end

    always @(negedge clk) begin
        if (wht_config_wren) begin
            logic [15:0] e;
            wr_cnt++;
            vecs++;
            assert (config_mode === 1'b1) else begin
                errs++;
                $error("FAIL wren_mode observed=%0h expected=1", config_mode);
            end
            vecs++;
            assert (exp_q.size() != 0) else begin
                errs++;
                $error("FAIL wren_extra observed=wren expected=no_wren");
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                vecs++;
                assert (wht_config_data === e) else begin
                    errs++;
                    $error("FAIL wr_data observed=%0h expected=%0h",
                           wht_config_data, e);
                end
            end
        end
        if (config_done) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_job(input logic [15:0] nk);
        wr_cnt = 0;
        done_cnt = 0;
        job_accept = 1'b1;
        step(1);
        job_accept = 1'b0;
        kernel_config_valid = 1'b1;
        num_kernels = nk;
        step(1);
        kernel_config_valid = 1'b0;
    endtask

    // Present n beats; half selects 50% valid duty. Returns #1 after the
    // edge that accepted the last beat.
    task automatic feed(input int n, input bit half,
                        input logic [15:0] d0, input logic [15:0] dinc);
        int sent = 0;
        int cyc = 0;
        bit ph = 1'b1;
        logic [15:0] d = d0;
        logic rdy;
        while (sent < n && cyc < 3000) begin
            wht_in_valid = half ? ph : 1'b1;
            ph = ~ph;
            wht_in_data = d;
            rdy = wht_in_ready;
            step(1);
            cyc++;
            if (wht_in_valid && rdy) begin
                sent++;
                d = d + dinc;
            end
        end
        wht_in_valid = 1'b0;
        chk("feed_beats", sent, n);
    endtask

    initial begin
        step(2);
        chk("rst_ready", wht_in_ready, 0);
        chk("rst_mode", config_mode, 0);
        chk("rst_wren", wht_config_wren, 0);
        chk("rst_data", wht_config_data, 0);
        chk("rst_done", config_done, 0);
        chk("rst_err", cfg_error, 0);
        rst = 1'b0;

        // kernel_config_valid in IDLE must not start a load
        kernel_config_valid = 1'b1;
        step(2);
        kernel_config_valid = 1'b0;
        chk("idle_kcv_ready", wht_in_ready, 0);
        chk("idle_kcv_mode", config_mode, 0);

        // single kernel, continuous beats 1..9
        start_job(16'd0);
        chk("t1_mode_up", config_mode, 1);
        chk("t1_ready_up", wht_in_ready, 1);
        feed(9, 1'b0, 16'h0001, 16'h0001);
        chk("t1_last_wren", wht_config_wren, 1);
        chk("t1_last_data", wht_config_data, 16'h0009);
        chk("t1_last_mode", config_mode, 1);
        chk("t1_ready_drop", wht_in_ready, 0);
        chk("t1_done_early", config_done, 0);
        step(1);
        chk("t1_done", config_done, 1);
        chk("t1_mode_down", config_mode, 0);
        chk("t1_wren_off", wht_config_wren, 0);
        step(1);
        chk("t1_done_pulse", config_done, 0);
        chk("t1_writes", wr_cnt, 9);
        chk("t1_done_cnt", done_cnt, 1);

        // four kernels, 50% valid; stray kernel_config_valid in LOAD ignored
        start_job(16'd3);
        kernel_config_valid = 1'b1;
        num_kernels = 16'd10;
        step(1);
        kernel_config_valid = 1'b0;
        feed(36, 1'b1, 16'h1000, 16'h0011);
        step(3);
        chk("t2_writes", wr_cnt, 36);
        chk("t2_done_cnt", done_cnt, 1);
        chk("t2_err", cfg_error, 0);
        chk("t2_q_empty", exp_q.size(), 0);

        // abort after 14 beats, then reconfigure for 2 kernels
        start_job(16'd2);
        feed(14, 1'b0, 16'h2000, 16'h0001);
        wht_in_valid = 1'b1;
        job_accept = 1'b1;
        step(1);
        job_accept = 1'b0;
        chk("t3_abort_wren", wht_config_wren, 0);
        chk("t3_abort_mode", config_mode, 0);
        chk("t3_abort_ready", wht_in_ready, 0);
        step(3);
        chk("t3_abort_writes", wr_cnt, 14);
        chk("t3_abort_done", done_cnt, 0);
        wr_cnt = 0;
        kernel_config_valid = 1'b1;
        num_kernels = 16'd1;
        step(1);
        kernel_config_valid = 1'b0;
        feed(18, 1'b0, 16'h3000, 16'h0003);
        step(3);
        chk("t3_writes", wr_cnt, 18);
        chk("t3_done_cnt", done_cnt, 1);

        // capacity overflow clamps to 64 kernels
        start_job(16'd100);
        chk("t4_err_set", cfg_error, 1);
        feed(576, 1'b0, 16'h4000, 16'h0007);
        wht_in_valid = 1'b1;
        step(4);
        wht_in_valid = 1'b0;
        chk("t4_writes", wr_cnt, 576);
        chk("t4_done_cnt", done_cnt, 1);
        chk("t4_err_hold", cfg_error, 1);
        job_accept = 1'b1;
        step(1);
        job_accept = 1'b0;
        chk("t4_err_clr", cfg_error, 0);

        // reset in the middle of a load
        start_job(16'd0);
        feed(5, 1'b0, 16'h5000, 16'h0001);
        wht_in_valid = 1'b1;
        rst = 1'b1;
        step(1);
        chk("t5_ready", wht_in_ready, 0);
        chk("t5_mode", config_mode, 0);
        chk("t5_wren", wht_config_wren, 0);
        chk("t5_data", wht_config_data, 0);
        chk("t5_done", config_done, 0);
        rst = 1'b0;
        step(3);
        chk("t5_ready_idle", wht_in_ready, 0);
        job_accept = 1'b1;
        step(1);
        job_accept = 1'b0;
        chk("t5_ready_wait", wht_in_ready, 0);
        wht_in_valid = 1'b0;
        kernel_config_valid = 1'b1;
        num_kernels = 16'd0;
        step(1);
        kernel_config_valid = 1'b0;
        chk("t5_ready_load", wht_in_ready, 1);
        chk("t5_writes", wr_cnt, 5);

`ifdef CNN_LAYER_ACCEL_WHT_CHECKSUM_EN
        start_job(16'd0);
        feed(9, 1'b0, 16'hFFFF, 16'h0000);
        step(1);
        chk("t6_done", config_done, 1);
        chk("t6_checksum", wht_checksum, 16'hFFF7);
`endif

        chk("end_q_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
